dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller that sits directly downstream of the memory stage. It consumes that stage's request (`mem_rea`, `mem_wea`, `mem_en`, `mem_addr`, `mem_din`), decodes each access to either on-chip block RAM or the MMIO slave port, and performs lane alignment in both directions. It returns `mem_dout` in the writeback cycle. It also generates `mem_hold`, which freezes the pipeline for the duration of variable-latency MMIO accesses.

## Interface
- `DMEM_AW`, 12: BRAM word-address width; BRAM word address = `mem_addr[DMEM_AW+1:2]`.
- `MMIO_BASE`, 32'h8000_0000: MMIO region base.
- `MMIO_MASK`, 32'hF000_0000: MMIO hit = `(mem_addr & MMIO_MASK) == MMIO_BASE`.
- `TIMEOUT`, 255: maximum BUSY cycles before an MMIO access is abandoned.

Ports:
- `clk` in 1: system clock, rising edge.
- `Rst` in 1: reset, asynchronous, active-low.
- `mem_rea` in 1: load request.
- `mem_wea` in 1: store request.
- `mem_en` in 4: byte-lane enables, already positioned by the memory stage.
- `mem_addr` in 32: byte address.
- `mem_din` in 32: store data, unshifted (byte/half in low bits).
- `stall_in` in 1: pipeline frozen by another source (dbg or f_stall).
- `mem_dout` out 32: read data, right-aligned (addressed byte at bits 7:0).
- `mem_hold` out 1: pipeline freeze request.
- `bram_en` out 1: BRAM enable.
- `bram_we` out 4: BRAM byte write enables.
- `bram_addr` out DMEM_AW: BRAM word address.
- `bram_din` out 32: BRAM write data.
- `bram_dout` in 32: BRAM read data, synchronous, 1-cycle latency.
- `mmio_valid` out 1: MMIO request valid.
- `mmio_we` out 1: MMIO write.
- `mmio_be` out 4: MMIO byte enables.
- `mmio_addr` out 32: MMIO address.
- `mmio_wdata` out 32: MMIO write data.
- `mmio_ready` in 1: MMIO completion; `mmio_rdata` is valid in the same cycle.
- `mmio_rdata` in 32: MMIO read data.
- `mmio_err` out 1: one-cycle pulse on MMIO timeout.

## Operation
- `off = mem_addr[1:0]`; `req = mem_rea | mem_wea`; `hit = req & MMIO hit`.
- Write lane alignment: write data = `mem_din` rotated left by 8*off, so `sh` at off=3 with `mem_en = 1001` wraps consistently.
- Read lane alignment: `mem_dout` = selected source rotated right by 8*`off_q`.
- BRAM path, combinational:
  - `bram_en = req & !hit & state==IDLE`.
  - `bram_we = mem_wea ? mem_en : 0`.
  - `bram_addr` = word address.
  - `bram_din` = aligned data.
- `off_q` and `src_q` (BRAM/MMIO) register the current `off` and `hit` every cycle that state is IDLE or DONE.
- `mem_dout` source is `bram_dout` when `src_q`=BRAM, `rdata_q` when `src_q`=MMIO.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if `hit`, then `mem_hold`=1 combinationally; on the edge, latch `mmio_we`/`be`/`addr`/`wdata` from the request, clear the counter, go to BUSY.
  - BUSY: `mmio_valid`=1 and `mem_hold`=1; counter increments.
    - `mmio_ready`: capture `rdata_q <= mmio_rdata`, go to DONE.
    - Counter == TIMEOUT-1 without ready: `rdata_q <= 32'hFFFF_FFFF`, pulse `mmio_err`, go to DONE.
  - DONE: `mem_hold`=0 and no new MMIO request is issued, even though the same request is still presented. Stay while `stall_in`=1; go to IDLE when `stall_in`=0 (the pipeline advances on that edge).
- Request payload (`mmio_addr`, `be`, `we`, `wdata`) is stable for the entire BUSY period.
- `mem_rea` and `mem_wea` both high is treated as a store.

## Timing
- Reset (async, `Rst`=0): state IDLE; `mmio_valid`, `mmio_we`, `mmio_be`, `mmio_addr`, `mmio_wdata`, `rdata_q`, `off_q`, `src_q`, counter, `mmio_err` all 0; `mem_hold`=0.
  - Reset asserted during BUSY drops `mmio_valid` immediately.
- BRAM load: request in cycle N; `mem_dout` valid in cycle N+1. `mem_hold` is never asserted.
- BRAM store: written at the edge ending cycle N. Repeats while the pipeline is stalled, which is idempotent.
- MMIO access, ready in the k-th BUSY cycle (k≥1):
  - `mem_hold` high for k+1 cycles.
  - DONE lasts at least 1 cycle.
  - `mem_dout` is valid in the cycle after DONE exits.
- Counter is 8 bits minimum; it never wraps before TIMEOUT.
- Exactly one MMIO transaction per pipeline request, including under `stall_in`.

## Test plan
- BRAM `sw` 0x1122_3344 to 0x100, then `lb` at 0x103 → `bram_we`=1111; next-cycle `mem_dout[7:0]`=0x11; `mem_hold` never 1.
- `sh` 0xABCD at offset 3 (`mem_en`=1001) → `bram_we`=1001, `bram_din`=0xCD??_??AB; `lhu` at the same address returns 0xABCD.
- MMIO `lw` at 0x8000_0010 with `mmio_ready` after 3 BUSY cycles and rdata 0xCAFE_F00D → `mem_hold` high 4 cycles, one `mmio_valid` burst, `mem_dout`=0xCAFE_F00D in the post-DONE cycle.
- MMIO store with `stall_in` held high 5 cycles after ready → state held in DONE, `mmio_valid` never reasserts, exactly 1 write observed.
- MMIO read, `mmio_ready` never asserted, TIMEOUT=255 → `mmio_err` pulses once after 255 BUSY cycles, `mem_dout`=0xFFFF_FFFF, `mem_hold` releases.
- `Rst` low mid-BUSY → `mmio_valid`, `mem_hold` go to 0 asynchronously; a subsequent BRAM load behaves normally.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// MMIO slave bus between dmem_ctrl and the peripheral fabric.
// Request fields stay stable while mmio_valid is high; mmio_ready completes with mmio_rdata.
interface dmem_ctrl_if;
    logic        mmio_valid;
    logic        mmio_we;
    logic [3:0]  mmio_be;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mmio_ready;
    logic [31:0] mmio_rdata;

    modport master (
        output mmio_valid, mmio_we, mmio_be, mmio_addr, mmio_wdata,
        input  mmio_ready, mmio_rdata
    );

    modport slave (
        input  mmio_valid, mmio_we, mmio_be, mmio_addr, mmio_wdata,
        output mmio_ready, mmio_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: BRAM loads return next cycle, MMIO holds the pipeline until ready/timeout.
// Backpressure via mem_hold during MMIO; DONE waits out stall_in so each request issues exactly once.
module dmem_ctrl #(
    parameter int          DMEM_AW   = 12,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter logic [31:0] MMIO_MASK = 32'hF000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               Rst,
    input  logic               mem_rea,
    input  logic               mem_wea,
    input  logic [3:0]         mem_en,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_din,
    input  logic               stall_in,
    output logic [31:0]        mem_dout,
    output logic               mem_hold,
    output logic               bram_en,
    output logic [3:0]         bram_we,
    output logic [DMEM_AW-1:0] bram_addr,
    output logic [31:0]        bram_din,
    input  logic [31:0]        bram_dout,
    dmem_ctrl_if.master        mmio,
    output logic               mmio_err
);
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [31:0] rotl8(input logic [31:0] d, input logic [1:0] o);
        case (o)
            2'd1:    rotl8 = {d[23:0], d[31:24]};
            2'd2:    rotl8 = {d[15:0], d[31:16]};
            2'd3:    rotl8 = {d[7:0],  d[31:8]};
            default: rotl8 = d;
        endcase
    endfunction

    function automatic logic [31:0] rotr8(input logic [31:0] d, input logic [1:0] o);
        case (o)
            2'd1:    rotr8 = {d[7:0],  d[31:8]};
            2'd2:    rotr8 = {d[15:0], d[31:16]};
            2'd3:    rotr8 = {d[23:0], d[31:24]};
            default: rotr8 = d;
        endcase
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    off_q, off_d;
    logic          src_q, src_d;
    logic          err_q, err_d;

    logic [1:0]  off;
    logic        req;
    logic        hit;
    logic [31:0] wdata_al;

    assign off      = mem_addr[1:0];
    assign req      = mem_rea | mem_wea;
    assign hit      = req & ((mem_addr & MMIO_MASK) == MMIO_BASE);
    assign wdata_al = rotl8(mem_din, off);

    assign bram_en   = req & ~hit & (state_q == ST_IDLE);
    assign bram_we   = mem_wea ? mem_en : 4'b0000;
    assign bram_addr = mem_addr[DMEM_AW+1:2];
    assign bram_din  = wdata_al;

    // Reset gates the hold so a request still on the bus cannot freeze the pipe while in reset.
    assign mem_hold = Rst & (((state_q == ST_IDLE) & hit) | (state_q == ST_BUSY));
    assign mem_dout = rotr8(src_q ? rdata_q : bram_dout, off_q);
    assign mmio_err = err_q;

    assign mmio.mmio_valid = (state_q == ST_BUSY);
    assign mmio.mmio_we    = we_q;
    assign mmio.mmio_be    = be_q;
    assign mmio.mmio_addr  = addr_q;
    assign mmio.mmio_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        off_d   = off_q;
        src_d   = src_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    we_d    = mem_wea;
                    be_d    = mem_en;
                    addr_d  = mem_addr;
                    wdata_d = wdata_al;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (mmio.mmio_ready) begin
                    rdata_d = mmio.mmio_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'hFFFF_FFFF;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The finished request is still presented here; leave only when the pipe advances.
                if (!stall_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            off_d = off;
            src_d = hit;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            off_q   <= 2'b00;
            src_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            off_q   <= off_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with a BRAM model and a programmable-latency MMIO slave.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Rst;
    logic        mem_rea, mem_wea, stall_in;
    logic [3:0]  mem_en;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout;
    logic        mem_hold;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [11:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout = 32'h0;
    logic        mmio_err;

    dmem_ctrl_if mif();

    dmem_ctrl #(
        .DMEM_AW(12), .MMIO_BASE(32'h8000_0000), .MMIO_MASK(32'hF000_0000), .TIMEOUT(255)
    ) dut (
        .clk(clk), .Rst(Rst),
        .mem_rea(mem_rea), .mem_wea(mem_wea), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_din(mem_din), .stall_in(stall_in),
        .mem_dout(mem_dout), .mem_hold(mem_hold),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout),
        .mmio(mif), .mmio_err(mmio_err)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // BRAM model: synchronous read of old data, byte-lane writes.
    logic [31:0] bmem [0:4095];
    always @(posedge clk) begin
        if (bram_en) begin
            bram_dout <= bmem[bram_addr];
            for (int i = 0; i < 4; i++)
                if (bram_we[i]) bmem[bram_addr][8*i +: 8] <= bram_din[8*i +: 8];
        end
    end

    // MMIO slave: ready in the ready_k-th valid cycle (0 = never).
    int          ready_k, busy_k, bursts, wr_cnt;
    logic [31:0] slave_rdata, wr_data, seen_addr;
    logic [3:0]  wr_be;
    logic        prev_valid = 1'b0;
    always @(negedge clk) begin
        if (mif.mmio_valid) begin
            if (!prev_valid) bursts++;
            busy_k++;
            if (busy_k == ready_k) begin
                mif.mmio_ready = 1'b1;
                mif.mmio_rdata = slave_rdata;
                seen_addr      = mif.mmio_addr;
                if (mif.mmio_we) begin
                    wr_cnt++;
                    wr_data = mif.mmio_wdata;
                    wr_be   = mif.mmio_be;
                end
            end else begin
                mif.mmio_ready = 1'b0;
            end
        end else begin
            busy_k         = 0;
            mif.mmio_ready = 1'b0;
            mif.mmio_rdata = 32'h0;
        end
        prev_valid = mif.mmio_valid;
    end

    // Scoreboard: a load retires on the edge where the pipe advances; data is due the next cycle.
    logic [31:0] exp_q[$];
    logic [31:0] msk_q[$];
    logic        chk_pend = 1'b0;
    int          hold_cyc, bram_cnt, err_cyc;
    logic [3:0]  snap_we;
    logic [31:0] snap_din, snap_addr;
    always @(negedge clk) begin
        if (chk_pend) begin
            chk_pend = 1'b0;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [31:0] e, m;
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                check("mem_dout", mem_dout & m, e & m);
            end
        end
        if (Rst && mem_rea && !mem_wea && !mem_hold && !stall_in) chk_pend = 1'b1;
        if (mem_hold) hold_cyc++;
        if (mmio_err) err_cyc++;
        if (bram_en) begin
            bram_cnt++;
            snap_we   = bram_we;
            snap_din  = bram_din;
            snap_addr = 32'(bram_addr);
        end
    end

    task automatic clr();
        hold_cyc = 0; bram_cnt = 0; err_cyc = 0; bursts = 0; wr_cnt = 0;
        snap_we = 4'h0; snap_din = 32'h0; snap_addr = 32'h0;
        wr_data = 32'h0; wr_be = 4'h0; seen_addr = 32'h0;
    endtask

    task automatic push(input logic [31:0] e, input logic [31:0] m);
        exp_q.push_back(e);
        msk_q.push_back(m);
    endtask

    // Entered and left at posedge+1; holds the request until the controller releases it.
    task automatic issue(input logic rea, input logic wea, input logic [3:0] en,
                         input logic [31:0] addr, input logic [31:0] din, input int stall_n);
        int guard = 0;
        mem_rea = rea; mem_wea = wea; mem_en = en; mem_addr = addr; mem_din = din;
        stall_in = (stall_n > 0);
        @(negedge clk);
        while (mem_hold && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) check("hold_release", 32'd0, 32'd1);
        for (int i = 0; i < stall_n; i++) begin
            @(posedge clk); #1;
            stall_in = (i < stall_n - 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        mem_rea = 1'b0; mem_wea = 1'b0; mem_en = 4'h0; mem_addr = 32'h0; mem_din = 32'h0;
        stall_in = 1'b0;
    endtask

    initial begin
        Rst = 1'b0; mem_rea = 1'b0; mem_wea = 1'b0; mem_en = 4'h0;
        mem_addr = 32'h0; mem_din = 32'h0; stall_in = 1'b0;
        ready_k = 0; slave_rdata = 32'h0;
        clr();
        repeat (2) @(negedge clk);
        check("rst_hold",  32'(mem_hold), 32'd0);
        check("rst_valid", 32'(mif.mmio_valid), 32'd0);
        check("rst_err",   32'(mmio_err), 32'd0);
        check("rst_addr",  mif.mmio_addr, 32'h0);
        check("rst_be",    32'(mif.mmio_be), 32'd0);
        check("rst_wdata", mif.mmio_wdata, 32'h0);
        check("rst_dout",  mem_dout, 32'h0);
        @(posedge clk); #1;
        Rst = 1'b1;

        clr();
        issue(1'b0, 1'b1, 4'b1111, 32'h0000_0100, 32'h1122_3344, 0);
        check("sw_we",   32'(snap_we), 32'h0000_000F);
        check("sw_din",  snap_din, 32'h1122_3344);
        check("sw_addr", snap_addr, 32'h0000_0040);
        check("sw_hold", hold_cyc, 0);

        clr();
        push(32'h0000_0011, 32'h0000_00FF);
        issue(1'b1, 1'b0, 4'b1000, 32'h0000_0103, 32'h0, 0);
        check("lb_we",    32'(snap_we), 32'h0);
        check("lb_en",    bram_cnt, 1);
        check("lb_hold",  hold_cyc, 0);

        clr();
        issue(1'b0, 1'b1, 4'b1001, 32'h0000_0203, 32'h0000_ABCD, 0);
        check("sh_we",  32'(snap_we), 32'h0000_0009);
        check("sh_din", snap_din & 32'hFF00_00FF, 32'hCD00_00AB);

        clr();
        push(32'h0000_ABCD, 32'h0000_FFFF);
        issue(1'b1, 1'b0, 4'b1001, 32'h0000_0203, 32'h0, 0);

        clr();
        ready_k = 3; slave_rdata = 32'hCAFE_F00D;
        push(32'hCAFE_F00D, 32'hFFFF_FFFF);
        issue(1'b1, 1'b0, 4'b1111, 32'h8000_0010, 32'h0, 0);
        check("mlw_hold",   hold_cyc, 4);
        check("mlw_bursts", bursts, 1);
        check("mlw_addr",   seen_addr, 32'h8000_0010);
        check("mlw_bram",   bram_cnt, 0);

        clr();
        ready_k = 2;
        issue(1'b0, 1'b1, 4'b1111, 32'h8000_0020, 32'h1234_5678, 5);
        check("msw_writes", wr_cnt, 1);
        check("msw_bursts", bursts, 1);
        check("msw_data",   wr_data, 32'h1234_5678);
        check("msw_be",     32'(wr_be), 32'h0000_000F);
        check("msw_hold",   hold_cyc, 3);

        clr();
        ready_k = 1;
        issue(1'b0, 1'b1, 4'b0010, 32'h8000_0021, 32'h0000_005A, 0);
        check("msb_data", wr_data, 32'h0000_5A00);
        check("msb_be",   32'(wr_be), 32'h0000_0002);
        check("msb_hold", hold_cyc, 2);

        clr();
        ready_k = 0;
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(1'b1, 1'b0, 4'b1111, 32'h8000_0040, 32'h0, 0);
        check("tmo_hold",   hold_cyc, 256);
        check("tmo_err",    err_cyc, 1);
        check("tmo_bursts", bursts, 1);

        clr();
        mem_rea = 1'b1; mem_en = 4'b1111; mem_addr = 32'h8000_0050;
        repeat (4) @(negedge clk);
        #2;
        Rst = 1'b0;
        #1;
        check("arst_valid", 32'(mif.mmio_valid), 32'd0);
        check("arst_hold",  32'(mem_hold), 32'd0);
        @(posedge clk); #1;
        mem_rea = 1'b0; mem_en = 4'h0; mem_addr = 32'h0;
        @(posedge clk); #1;
        Rst = 1'b1;

        clr();
        push(32'h1122_3344, 32'hFFFF_FFFF);
        issue(1'b1, 1'b0, 4'b1111, 32'h0000_0100, 32'h0, 0);
        check("post_hold", hold_cyc, 0);
        check("post_bram", bram_cnt, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
